// File: rtl/robo_limpa_tubos_pkg.sv
// -----------------------------------------------------------------------------
// robo_limpa_tubos_pkg
// Shared types and default constants for the pipe-cleaning robot controller.
//   state_e           : controller state encoding (3 bits)
//   REMOVE_STEPS_D    : default number of remove act steps to clear one trash cell
//   TURNS_PER_RIGHT_D : default number of left-turn pulses forming a right turn
//   cmd_t             : packed action command {front, turn, remove}
// -----------------------------------------------------------------------------
package robo_limpa_tubos_pkg;

  typedef enum logic [2:0] {
    SEARCH   = 3'd0,  // no wall acquired yet, walk straight
    FOLLOW   = 3'd1,  // wall on the left, keep it there
    FWD_LEFT = 3'd2,  // just turned into a left opening, step into it
    ROT      = 3'd3,  // finishing a right turn made of left pulses
    REMOVE   = 3'd4,  // clearing trash in the cell ahead
    DONE     = 3'd5   // standing on the exit, halted until reset
  } state_e;

  localparam int REMOVE_STEPS_D    = 3;
  localparam int TURNS_PER_RIGHT_D = 3;

  // Action command as one vector, ordered {front, turn, remove}.
  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_NONE   = 3'b000;
  localparam cmd_t CMD_FRONT  = 3'b100;
  localparam cmd_t CMD_TURN   = 3'b010;
  localparam cmd_t CMD_REMOVE = 3'b001;

endpackage

// File: rtl/robo_limpa_tubos_if.sv
// -----------------------------------------------------------------------------
// robo_limpa_tubos_if
// Sensor / action bundle between the world model and the robot controller.
//   head, left, under, barrier : cell sensors driven by the world
//   front, turn, remove        : one-bit action commands driven by the controller
// Modports:
//   master : controller side (reads sensors, drives actions)
//   slave  : world side (drives sensors, reads actions)
// -----------------------------------------------------------------------------
interface robo_limpa_tubos_if;

  logic head;     // wall or map edge directly ahead
  logic left;     // wall or map edge on the robot's left
  logic under;    // robot stands on the exit cell
  logic barrier;  // trash in the cell ahead
  logic front;    // advance one cell
  logic turn;     // rotate 90 degrees counter-clockwise
  logic remove;   // work on the trash ahead

  modport master (
    input  head,
    input  left,
    input  under,
    input  barrier,
    output front,
    output turn,
    output remove
  );

  modport slave (
    output head,
    output left,
    output under,
    output barrier,
    input  front,
    input  turn,
    input  remove
  );

endinterface

// File: rtl/robo_limpa_tubos_ctrl.sv
// -----------------------------------------------------------------------------
// robo_limpa_tubos_ctrl
// Left-wall-following controller for the pipe-cleaning robot. Runs a two-phase
// step: phase 0 is the world's sample cycle (no actions), phase 1 is the act
// cycle where one action is issued as a Mealy function of state and sensors.
// The state register only advances at the edge that closes an act cycle.
//
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous, active-low reset
//   bus       : robo_limpa_tubos_if.master (sensors in, actions out)
//   dbg_state : current state encoding   (only with ROBO_LIMPA_TUBOS_STATE_OUT_EN)
//   dbg_phase : current step phase       (only with ROBO_LIMPA_TUBOS_STATE_OUT_EN)
//
// Build option: define ROBO_LIMPA_TUBOS_STATE_OUT_EN to expose the debug ports.
// -----------------------------------------------------------------------------
module robo_limpa_tubos_ctrl
  import robo_limpa_tubos_pkg::*;
#(
  parameter int REMOVE_STEPS    = REMOVE_STEPS_D,
  parameter int TURNS_PER_RIGHT = TURNS_PER_RIGHT_D
) (
  input  logic                 clock,
  input  logic                 reset,
  robo_limpa_tubos_if.master   bus
`ifdef ROBO_LIMPA_TUBOS_STATE_OUT_EN
  ,
  output logic [2:0]           dbg_state,
  output logic                 dbg_phase
`endif
);

  // Counters are 2 bits wide; targets are truncated to that width.
  localparam logic [1:0] REMOVE_TARGET = REMOVE_STEPS[1:0];
  localparam logic [1:0] TURN_TARGET   = TURNS_PER_RIGHT[1:0];

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;       // walking state to resume after clearing trash
  logic       phase_q, phase_d;
  logic [1:0] tcnt_q, tcnt_d;     // left pulses issued in the current right turn
  logic [1:0] rcnt_q, rcnt_d;     // remove steps issued on the current trash cell
  logic [1:0] tcnt_inc, rcnt_inc;
  logic       act;
  logic       start_right;
  logic       start_remove;
  cmd_t       cmd;

  assign tcnt_inc = tcnt_q + 2'd1;
  assign rcnt_inc = rcnt_q + 2'd1;

  // Actions are only legal in the act phase and never while reset is held.
  assign act = phase_q & reset;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q <= 1'b0;
      state_q <= SEARCH;
      ret_q   <= SEARCH;
      tcnt_q  <= 2'd0;
      rcnt_q  <= 2'd0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      ret_q   <= ret_d;
      tcnt_q  <= tcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Mealy outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d      = ~phase_q;
    state_d      = state_q;
    ret_d        = ret_q;
    tcnt_d       = tcnt_q;
    rcnt_d       = rcnt_q;
    cmd          = CMD_NONE;
    start_right  = 1'b0;
    start_remove = 1'b0;

    if (act) begin
      unique case (state_q)
        SEARCH, FOLLOW, FWD_LEFT: begin
          // Exit beats trash, trash beats navigation.
          if (bus.under) begin
            state_d = DONE;
          end else if (bus.barrier) begin
            start_remove = 1'b1;
          end else begin
            unique case (state_q)
              SEARCH: begin
                if (!bus.head) cmd = CMD_FRONT;
                else           start_right = 1'b1;
              end
              FOLLOW: begin
                if (!bus.left) begin
                  // Opening on the left: pivot into it, step next act.
                  cmd     = CMD_TURN;
                  state_d = FWD_LEFT;
                end else if (!bus.head) begin
                  cmd = CMD_FRONT;
                end else begin
                  start_right = 1'b1;
                end
              end
              default: begin  // FWD_LEFT
                if (!bus.head) begin
                  cmd     = CMD_FRONT;
                  state_d = FOLLOW;
                end else begin
                  start_right = 1'b1;
                end
              end
            endcase
          end
        end

        ROT: begin
          cmd = CMD_TURN;
          if (tcnt_inc == TURN_TARGET) begin
            tcnt_d  = 2'd0;
            state_d = FOLLOW;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end

        REMOVE: begin
          cmd = CMD_REMOVE;
          if (rcnt_inc == REMOVE_TARGET) begin
            rcnt_d  = 2'd0;
            state_d = ret_q;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = SEARCH;
        end
      endcase

      // First pulse of a right turn; the remaining pulses come from ROT.
      // A one-pulse target completes immediately.
      if (start_right) begin
        cmd = CMD_TURN;
        if (TURN_TARGET == 2'd1) begin
          tcnt_d  = 2'd0;
          state_d = FOLLOW;
        end else begin
          tcnt_d  = 2'd1;
          state_d = ROT;
        end
      end

      // First remove step; remember where to resume once the cell is clear.
      if (start_remove) begin
        cmd = CMD_REMOVE;
        if (REMOVE_TARGET == 2'd1) begin
          rcnt_d  = 2'd0;
          state_d = state_q;
        end else begin
          rcnt_d  = 2'd1;
          ret_d   = state_q;
          state_d = REMOVE;
        end
      end
    end
  end

  assign bus.front  = cmd[2];
  assign bus.turn   = cmd[1];
  assign bus.remove = cmd[0];

`ifdef ROBO_LIMPA_TUBOS_STATE_OUT_EN
  assign dbg_state = state_q;
  assign dbg_phase = phase_q;
`endif

endmodule

// File: tb/tb_robo_limpa_tubos_ctrl.sv
// -----------------------------------------------------------------------------
// tb_robo_limpa_tubos_ctrl
// Directed stimulus with a scoreboard queue: every driven cycle pushes the
// expected {front, turn, remove}; a monitor on the falling edge pops and checks.
// -----------------------------------------------------------------------------
module tb_robo_limpa_tubos_ctrl;
  import robo_limpa_tubos_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  robo_limpa_tubos_if bus ();

`ifdef ROBO_LIMPA_TUBOS_STATE_OUT_EN
  logic [2:0] dbg_state;
  logic       dbg_phase;
`endif

  robo_limpa_tubos_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus)
`ifdef ROBO_LIMPA_TUBOS_STATE_OUT_EN
    ,
    .dbg_state (dbg_state),
    .dbg_phase (dbg_phase)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    cmd_t  cmd;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam cmd_t Z = CMD_NONE;
  localparam cmd_t F = CMD_FRONT;
  localparam cmd_t T = CMD_TURN;
  localparam cmd_t R = CMD_REMOVE;

  // One clock cycle of stimulus plus its expected action.
  task automatic cyc(input logic rst_n, input logic h, input logic l,
                     input logic u, input logic b, input cmd_t exp,
                     input string name);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst_n;
    bus.head    = h;
    bus.left    = l;
    bus.under   = u;
    bus.barrier = b;
    e.cmd  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Full step: sample cycle (no action) then act cycle, sensors held stable.
  task automatic step(input logic h, input logic l, input logic u,
                      input logic b, input cmd_t exp, input string name);
    cyc(1'b1, h, l, u, b, Z, {name, "_idle"});
    cyc(1'b1, h, l, u, b, exp, name);
  endtask

  task automatic do_reset(input string name);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, {name, "_rst0"});
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, {name, "_rst1"});
  endtask

  // Monitor: outputs are presented every cycle, compare mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    cmd_t got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {bus.front, bus.turn, bus.remove};
      checks++;
      if (got !== e.cmd) begin
        errors++;
        $display("FAIL %s got=%b expected=%b (front,turn,remove)", e.name, got, e.cmd);
      end else begin
        $display("ok   %s cmd=%b", e.name, got);
      end
    end
  end

  initial begin
    bus.head    = 1'b0;
    bus.left    = 1'b0;
    bus.under   = 1'b0;
    bus.barrier = 1'b0;

    // Reset state and straight walk in SEARCH.
    do_reset("init");
    step(0, 0, 0, 0, F, "search_fwd1");
    step(0, 0, 0, 0, F, "search_fwd2");
    step(0, 0, 0, 0, F, "search_fwd3");

    // Wall ahead in SEARCH: three turn pulses (ROT ignores sensors), then FOLLOW.
    step(1, 0, 0, 0, T, "search_right1");
    step(0, 0, 1, 1, T, "rot_right2");
    step(1, 1, 0, 1, T, "rot_right3");
    step(0, 1, 0, 0, F, "follow_fwd");

    // Left opening in FOLLOW: one turn, then step into it, back in FOLLOW.
    step(0, 0, 0, 0, T, "follow_left_turn");
    step(0, 0, 0, 0, F, "fwdleft_fwd");
    step(0, 1, 0, 0, F, "follow_again");

    // FOLLOW -> FWD_LEFT -> blocked ahead -> right turn -> FOLLOW.
    step(0, 0, 0, 0, T, "follow_left_turn2");
    step(1, 0, 0, 0, T, "fwdleft_right1");
    step(0, 0, 0, 0, T, "rot2_right2");
    step(0, 0, 0, 0, T, "rot2_right3");
    step(0, 1, 0, 0, F, "follow_after_rot");

    // Trash in FOLLOW: exactly three removes regardless of sensors, resume FOLLOW.
    step(0, 1, 0, 1, R, "follow_remove1");
    step(1, 0, 1, 1, R, "remove2");
    step(0, 0, 0, 0, R, "remove3");
    step(0, 1, 0, 0, F, "follow_after_remove");
    step(0, 0, 0, 0, T, "follow_ret_check");

    // Trash in FWD_LEFT (barrier beats head): resume in FWD_LEFT, not FOLLOW.
    step(1, 0, 0, 1, R, "fwdleft_remove1");
    step(1, 0, 0, 1, R, "fl_remove2");
    step(1, 0, 0, 1, R, "fl_remove3");
    step(0, 0, 0, 0, F, "fwdleft_resumed");

    // Exit cell beats trash: halt forever, even once under drops.
    step(0, 1, 1, 1, Z, "follow_exit");
    step(0, 0, 0, 0, Z, "done_hold1");
    step(1, 1, 0, 1, Z, "done_hold2");
    step(0, 1, 0, 0, Z, "done_hold3");

    // One reset edge leaves DONE; SEARCH resumes.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, "exit_rst");
    step(0, 0, 0, 0, F, "search_after_done");

    // Reset during the second ROT pulse discards the partial turn.
    step(1, 0, 0, 0, T, "search_right_abort");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Z, "rot_abort_idle");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Z, "rot_abort_rst");
    step(0, 0, 0, 0, F, "search_no_leftover");

    // Dead end: two successive right turns, then a free cell.
    step(1, 1, 0, 0, T, "deadend_r1a");
    step(1, 1, 0, 0, T, "deadend_r1b");
    step(1, 1, 0, 0, T, "deadend_r1c");
    step(1, 1, 0, 0, T, "deadend_r2a");
    step(1, 1, 0, 0, T, "deadend_r2b");
    step(1, 1, 0, 0, T, "deadend_r2c");
    step(0, 1, 0, 0, F, "deadend_free");

    // Trash in SEARCH resumes SEARCH (straight walk with no wall).
    step(0, 0, 0, 0, T, "follow_left3");
    do_reset("mid");
    step(0, 0, 0, 1, R, "search_remove1");
    step(0, 0, 0, 0, R, "s_remove2");
    step(0, 0, 0, 0, R, "s_remove3");
    step(0, 0, 0, 0, F, "search_resumed");

    // Drain the scoreboard.
    repeat (3) @(posedge clock);
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
